// File: rtl/raster_stream_fifo.sv
// Valid/ready sample FIFO with a registered show-ahead output, live fill level,
// almost-full/almost-empty flags and a sticky overflow flag with a saturating drop counter.
module raster_stream_fifo #(
    parameter int DAT_WID   = 24,
    parameter int DEPTH_WID = 11,
    parameter int DEPTH     = 1500,
    parameter int AFULL_TH  = DEPTH - 16,
    parameter int AEMPTY_TH = 16,
    parameter int DROP_WID  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [DAT_WID-1:0]   wr_dat,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic [DAT_WID-1:0]   rd_dat,
    output logic [DEPTH_WID-1:0] level,
    output logic                 afull,
    output logic                 aempty,
    output logic                 overflow,
    output logic [DROP_WID-1:0]  drop_cnt,
    input  logic                 clr_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [DEPTH_WID-1:0] DEPTH_L  = DEPTH_WID'(DEPTH);
    localparam logic [DEPTH_WID-1:0] LAST_L   = DEPTH_WID'(DEPTH - 1);
    localparam logic [DEPTH_WID-1:0] AFULL_L  = DEPTH_WID'(AFULL_TH);
    localparam logic [DEPTH_WID-1:0] AEMPTY_L = DEPTH_WID'(AEMPTY_TH);
    localparam logic [DEPTH_WID-1:0] ONE_L    = DEPTH_WID'(1);
    localparam logic [DROP_WID-1:0]  DROP_ONE = DROP_WID'(1);
    localparam logic [DROP_WID-1:0]  DROP_MAX = '1;

    logic [DAT_WID-1:0]   mem [DEPTH];
    logic [DEPTH_WID-1:0] wp;
    logic [DEPTH_WID-1:0] rp;
    logic [DEPTH_WID-1:0] ram_cnt;
    logic                 wr_fire;
    logic                 rd_fire;
    logic                 fetch;
    logic                 drop;

    // No pass-through: a read at full does not open wr_ready in the same cycle.
    assign wr_ready = (level != DEPTH_L);
    assign afull    = (level >= AFULL_L);
    assign aempty   = (level <= AEMPTY_L);

    assign wr_fire = wr_valid && wr_ready;
    assign drop    = wr_valid && !wr_ready;
    assign rd_fire = rd_valid && rd_ready;
    // Fetch only from words already in RAM, so it never reads the word being written.
    assign fetch   = (ram_cnt != '0) && (!rd_valid || rd_ready);

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wp[AW-1:0]] <= wr_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp       <= '0;
            rp       <= '0;
            ram_cnt  <= '0;
            rd_valid <= 1'b0;
            rd_dat   <= '0;
            level    <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (wr_fire) begin
                wp <= (wp == LAST_L) ? '0 : wp + ONE_L;
            end

            if (fetch) begin
                rd_dat   <= mem[rp[AW-1:0]];
                rp       <= (rp == LAST_L) ? '0 : rp + ONE_L;
                rd_valid <= 1'b1;
            end else if (rd_fire) begin
                rd_valid <= 1'b0;
            end

            case ({wr_fire, fetch})
                2'b10:   ram_cnt <= ram_cnt + ONE_L;
                2'b01:   ram_cnt <= ram_cnt - ONE_L;
                default: ram_cnt <= ram_cnt;
            endcase

            case ({wr_fire, rd_fire})
                2'b10:   level <= level + ONE_L;
                2'b01:   level <= level - ONE_L;
                default: level <= level;
            endcase

            // A drop coinciding with a clear is still recorded as the first new drop.
            if (clr_err) begin
                overflow <= drop;
                drop_cnt <= drop ? DROP_ONE : '0;
            end else if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != DROP_MAX) begin
                    drop_cnt <= drop_cnt + DROP_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_raster_stream_fifo.sv
// Bench for raster_stream_fifo: a DEPTH=8 instance driven from a vector table plus
// a DEPTH=5 instance for streaming/wrap, with data order checked by scoreboards.
module tb_raster_stream_fifo;

    localparam int DW = 24;
    localparam int LW = 11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic          a_wv, a_wr, a_rv, a_rr, a_af, a_ae, a_ovf, a_clr;
    logic [DW-1:0] a_wd, a_rd;
    logic [LW-1:0] a_lvl;
    logic [3:0]    a_drop;

    logic          b_wv, b_wr, b_rv, b_rr, b_af, b_ae, b_ovf, b_clr;
    logic [DW-1:0] b_wd, b_rd;
    logic [LW-1:0] b_lvl;
    logic [15:0]   b_drop;

    raster_stream_fifo #(
        .DAT_WID(DW), .DEPTH_WID(LW), .DEPTH(8),
        .AFULL_TH(6), .AEMPTY_TH(2), .DROP_WID(4)
    ) u_a (
        .clk(clk), .rst(rst),
        .wr_valid(a_wv), .wr_ready(a_wr), .wr_dat(a_wd),
        .rd_valid(a_rv), .rd_ready(a_rr), .rd_dat(a_rd),
        .level(a_lvl), .afull(a_af), .aempty(a_ae),
        .overflow(a_ovf), .drop_cnt(a_drop), .clr_err(a_clr)
    );

    raster_stream_fifo #(
        .DAT_WID(DW), .DEPTH_WID(LW), .DEPTH(5),
        .AFULL_TH(4), .AEMPTY_TH(1), .DROP_WID(16)
    ) u_b (
        .clk(clk), .rst(rst),
        .wr_valid(b_wv), .wr_ready(b_wr), .wr_dat(b_wd),
        .rd_valid(b_rv), .rd_ready(b_rr), .rd_dat(b_rd),
        .level(b_lvl), .afull(b_af), .aempty(b_ae),
        .overflow(b_ovf), .drop_cnt(b_drop), .clr_err(b_clr)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Scoreboards: push on accepted write, pop and compare on read handshake.
    logic [DW-1:0] sa[$];
    logic [DW-1:0] sb[$];

    always @(negedge clk) begin
        if (rst) begin
            sa.delete();
            sb.delete();
        end else begin
            if (a_rv && a_rr) begin
                if (sa.size() == 0) begin
                    n_chk++;
                    $display("FAIL a.sb_pop: read of 0x%0h with no word outstanding", a_rd);
                end else chk("a.sb_data", 32'(a_rd), 32'(sa.pop_front()));
            end
            if (a_wv && a_wr) sa.push_back(a_wd);
            if (b_rv && b_rr) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    $display("FAIL b.sb_pop: read of 0x%0h with no word outstanding", b_rd);
                end else chk("b.sb_data", 32'(b_rd), 32'(sb.pop_front()));
            end
            if (b_wv && b_wr) sb.push_back(b_wd);
        end
    end

    typedef struct {
        logic          wv;
        logic [DW-1:0] wd;
        logic          rr;
        logic          clr;
        int            lvl;
        logic          rv;
        logic [DW-1:0] rdat;
        logic          ovf;
        int            drop;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic wv, input logic [DW-1:0] wd, input logic rr,
                                input logic clr, input int lvl, input logic rv,
                                input logic [DW-1:0] rdat, input logic ovf, input int drop);
        vec_t v;
        v.wv = wv; v.wd = wd; v.rr = rr; v.clr = clr;
        v.lvl = lvl; v.rv = rv; v.rdat = rdat; v.ovf = ovf; v.drop = drop;
        vecs.push_back(v);
    endfunction

    task automatic chk_idle_a(input string tag);
        chk({tag, ".wr_ready"}, 32'(a_wr), 1);
        chk({tag, ".rd_valid"}, 32'(a_rv), 0);
        chk({tag, ".rd_dat"},   32'(a_rd), 0);
        chk({tag, ".level"},    32'(a_lvl), 0);
        chk({tag, ".afull"},    32'(a_af), 0);
        chk({tag, ".aempty"},   32'(a_ae), 1);
        chk({tag, ".overflow"}, 32'(a_ovf), 0);
        chk({tag, ".drop_cnt"}, 32'(a_drop), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int lat;

    initial begin
        rst = 1'b1;
        a_wv = 0; a_wd = '0; a_rr = 0; a_clr = 0;
        b_wv = 0; b_wd = '0; b_rr = 0; b_clr = 0;

        // Fill 0..7 with no reader: latency, full, thresholds on the way up.
        for (int i = 0; i < 8; i++) add(1, DW'(i), 0, 0, i, (i >= 2), '0, 0, 0);
        add(0, '0, 0, 0, 8, 1, '0, 0, 0);
        // Full with simultaneous read: read completes, write dropped.
        add(1, DW'(99), 1, 0, 8, 1, '0, 0, 0);
        add(1, DW'(8), 0, 0, 7, 1, DW'(1), 1, 1);
        // Hold writes on a full FIFO: saturation at 15.
        for (int k = 0; k < 20; k++) add(1, DW'(77), 0, 0, 8, 1, DW'(1), 1, (k + 1 > 15) ? 15 : k + 1);
        add(1, DW'(77), 0, 1, 8, 1, DW'(1), 1, 15);
        add(0, '0, 0, 1, 8, 1, DW'(1), 1, 1);
        add(0, '0, 0, 0, 8, 1, DW'(1), 0, 0);
        // Drain 8..1: thresholds on the way down; last word popped without refill.
        for (int l = 8; l >= 1; l--) add(0, '0, 1, 0, l, 1, DW'(9 - l), 0, 0);
        add(0, '0, 0, 0, 0, 0, DW'(8), 0, 0);

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_idle_a("reset");
        chk("b.reset.level", 32'(b_lvl), 0);
        chk("b.reset.rd_valid", 32'(b_rv), 0);
        chk("b.reset.wr_ready", 32'(b_wr), 1);
        chk("b.reset.afull", 32'(b_af), 0);
        chk("b.reset.aempty", 32'(b_ae), 1);

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            a_wv = vecs[i].wv; a_wd = vecs[i].wd; a_rr = vecs[i].rr; a_clr = vecs[i].clr;
            @(negedge clk);
            chk($sformatf("v%0d.level", i),    32'(a_lvl), 32'(vecs[i].lvl));
            chk($sformatf("v%0d.wr_ready", i), 32'(a_wr),  32'(vecs[i].lvl != 8));
            chk($sformatf("v%0d.afull", i),    32'(a_af),  32'(vecs[i].lvl >= 6));
            chk($sformatf("v%0d.aempty", i),   32'(a_ae),  32'(vecs[i].lvl <= 2));
            chk($sformatf("v%0d.rd_valid", i), 32'(a_rv),  32'(vecs[i].rv));
            chk($sformatf("v%0d.rd_dat", i),   32'(a_rd),  32'(vecs[i].rdat));
            chk($sformatf("v%0d.overflow", i), 32'(a_ovf), 32'(vecs[i].ovf));
            chk($sformatf("v%0d.drop_cnt", i), 32'(a_drop), 32'(vecs[i].drop));
        end
        @(posedge clk);
        #1 a_wv = 0; a_rr = 0; a_clr = 0;
        chk("a.sb_empty_after_table", 32'(sa.size()), 0);

        // Streaming through DEPTH=5: word i is read in cycle i+2; two words in
        // flight in steady state (one in RAM, one in the output register).
        b_rr = 1;
        for (int i = 0; i < 27; i++) begin
            b_wv = (i < 23);
            b_wd = DW'(i) ^ 24'hA50000;
            @(negedge clk);
            chk($sformatf("s%0d.wr_ready", i), 32'(b_wr), 1);
            if (i < 2) chk($sformatf("s%0d.level", i), 32'(b_lvl), 32'(i));
            if (i >= 2 && i < 23) chk($sformatf("s%0d.level", i), 32'(b_lvl), 2);
            if (i >= 2 && i < 25) begin
                chk($sformatf("s%0d.rd_valid", i), 32'(b_rv), 1);
                chk($sformatf("s%0d.rd_dat", i), 32'(b_rd), 32'(DW'(i - 2) ^ 24'hA50000));
            end else chk($sformatf("s%0d.rd_valid", i), 32'(b_rv), 0);
            @(posedge clk);
            #1;
        end
        b_wv = 0; b_rr = 0;
        @(negedge clk);
        chk("b.sb_empty", 32'(sb.size()), 0);
        chk("b.level_end", 32'(b_lvl), 0);
        chk("b.overflow", 32'(b_ovf), 0);
        chk("b.drop_cnt", 32'(b_drop), 0);

        // Reset mid-stream at level 5, with write/read also asserted during rst.
        @(posedge clk);
        #1 a_wv = 1;
        for (int i = 0; i < 5; i++) begin
            a_wd = DW'(100 + i);
            @(posedge clk);
            #1;
        end
        a_wv = 0;
        @(negedge clk);
        chk("pre_rst.level", 32'(a_lvl), 5);
        chk("pre_rst.rd_valid", 32'(a_rv), 1);
        @(posedge clk);
        #1 rst = 1; a_wv = 1; a_wd = 24'h123456; a_rr = 1; a_clr = 0;
        @(posedge clk);
        #1 rst = 0; a_wv = 0; a_rr = 0;
        @(negedge clk);
        chk_idle_a("post_rst");

        @(posedge clk);
        #1 a_wv = 1; a_wd = 24'h7FFFFF;
        @(posedge clk);
        #1 a_wv = 0;
        lat = 1;
        @(negedge clk);
        while (!a_rv && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("rst.latency", 32'(lat), 2);
        chk("rst.rd_dat", 32'(a_rd), 32'h7FFFFF);
        chk("rst.level", 32'(a_lvl), 1);
        @(posedge clk);
        #1 a_rr = 1;
        @(posedge clk);
        #1 a_rr = 0;
        @(negedge clk);
        chk("rst.rd_valid_after_pop", 32'(a_rv), 0);
        chk("rst.level_after_pop", 32'(a_lvl), 0);
        chk("rst.rd_dat_held", 32'(a_rd), 32'h7FFFFF);
        chk("a.sb_empty_end", 32'(sa.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
